isa_io_target: RTL and testbench
================================

// Module: isa_io_target
// PURPOSE
//  ISA I/O-cycle responder (target side of the riser's ISA interface). Samples IOR#/IOW#
//  from the ISA bus, decodes a 16-register I/O window, and bridges hits to a fabric-side
//  read request / write FIFO. Stretches cycles with IOCHRDY; sits beside the ISA bus master in soc_system.
// PARAMETERS
//  BASE_ADDR    16'h0220  I/O window base; must be aligned to 16 (SA[3:0] selects register)
//  SYNC_STAGES  2         flops on ior_n/iow_n/aen before edge detection (>=2)
//  WAIT_MAX     64        max clk cycles IOCHRDY is held low before timeout
//  FIFO_DEPTH   8         write FIFO entries (power of 2)
// PORTS
//  clk            in   1   system clock
//  reset          in   1   async, active-high
//  isa_sa         in   16  ISA I/O address SA[15:0]
//  isa_aen        in   1   high = DMA cycle; suppresses decode
//  isa_ior_n      in   1   I/O read strobe, async
//  isa_iow_n      in   1   I/O write strobe, async
//  isa_sbhe_n     in   1   byte-high enable
//  isa_data_in    in   16  SD bus input
//  isa_data_out   out  16  SD bus output value
//  isa_data_oe    out  1   drive SD bus
//  isa_iochrdy_oe out  1   1 = pull IOCHRDY low (not ready)
//  isa_iocs16_oe  out  1   1 = pull IOCS16# low
//  rd_req         out  1   fabric read request, held until rd_valid
//  rd_addr        out  4   register index
//  rd_data        in   16  fabric read data
//  rd_valid       in   1   rd_data valid; single-cycle pulse
//  wr_valid       out  1   write FIFO not empty
//  wr_ready       in   1   pop when wr_valid && wr_ready
//  wr_addr        out  4   head entry register index
//  wr_data        out  16  head entry data
//  wr_be          out  2   head entry byte enables
//  timeout        out  1   one-cycle pulse on IOCHRDY timeout
// BEHAVIOUR
//  - Reset: every output 0; FIFO emptied; FSM -> IDLE. Reset mid-cycle releases SD and IOCHRDY immediately.
//  - Strobes and aen pass through SYNC_STAGES flops; falling edge of synced strobe starts a cycle.
//  - Hit = !aen_s && isa_sa[15:4]==BASE_ADDR[15:4]; sa/sbhe_n captured on the start edge. Misses are ignored.
//  - Read and write strobes low together: read wins; the write is ignored.
//  - FSM: IDLE -> RD_WAIT | WR_PUSH | WR_STALL; RD_WAIT -> RD_DRIVE; WR_STALL -> WR_PUSH;
//    RD_DRIVE, WR_PUSH -> DONE; DONE -> IDLE.
//  - IDLE: on read hit, enter RD_WAIT with rd_req=1 and iochrdy_oe=1, registered in the same cycle.
//  - RD_WAIT: when rd_valid=1, latch rd_data into isa_data_out and enter RD_DRIVE; iochrdy_oe drops next cycle.
//  - RD_DRIVE: data_oe=1 until the synced ior_n rises, then DONE.
//  - Write hit, FIFO not full: push {sa[3:0], data_in, be} directly, entering WR_PUSH; no wait states.
//  - Write hit, FIFO full: WR_STALL with iochrdy_oe=1; push on the first free slot.
//    A pop and push in the same cycle on a full FIFO is legal.
//  - be = {!sbhe_n, 1'b1}. data_in is sampled two clk cycles after the synced strobe edge.
//  - Wait counter: reset on cycle start; saturates at WAIT_MAX.
//    At WAIT_MAX: reads drive 16'hFFFF and go to RD_DRIVE; stalled writes are dropped and go to DONE.
//    Both release iochrdy_oe and pulse timeout. A late rd_valid is ignored.
//  - DONE: waits for both synced strobes high; data_oe=0 throughout. No new cycle is accepted before then.
//  - FIFO pointers are FIFO_DEPTH-wrapping with an extra wrap bit; full/empty come from the pointer compare.
// CONFIGURATION
//  ISA_IOCS16_EN defined: 16-bit responder.
//    iocs16_oe = address hit, combinational on isa_sa; isa_data_out is the full 16 bits; be as above.
//  Undefined: 8-bit only. iocs16_oe tied 0; isa_data_out[15:8]=0.
//    be forced to 2'b01; write data[15:8] stored as 0.
// STRUCTURE
//  isa_io_pkg: state enum (IDLE, RD_WAIT, RD_DRIVE, WR_PUSH, WR_STALL, DONE),
//    typedef wr_entry_t {addr[3:0], data[15:0], be[1:0]}, constant RD_TIMEOUT_DATA=16'hFFFF.
//  Sub-module isa_io_wr_fifo: sync FIFO of wr_entry_t, DEPTH parameter, full/empty.
//  Synchronizers and FSM stay inline.
// TESTING
//  1 Read hit: SA=0x022A, IOR# low, rd_valid after 5 clk with 0xBEEF
//    -> rd_addr=0xA, iochrdy_oe high <=5+SYNC+1 clk, SD=0xBEEF until IOR# high.
//  2 Miss/DMA: IOR# at SA=0x0330, and at SA=0x0224 with AEN=1
//    -> no rd_req, data_oe and iochrdy_oe stay 0.
//  3 Write burst: 8 IOW# to 0x0220..0x0227 with wr_ready=0 -> 8 entries;
//    9th IOW# stalls with iochrdy_oe=1; wr_ready=1 completes the push with entries in order.
//  4 Timeouts: read with rd_valid withheld -> SD=0xFFFF, timeout pulse at WAIT_MAX;
//    full-FIFO write -> entry dropped, timeout pulse.
//  5 Reset mid-read (RD_WAIT) -> all outputs 0 asynchronously; next read completes normally.
//  6 8/16-bit: IOW# with SBHE#=0, SD=0x1234 -> ISA_IOCS16_EN defined: be=11, data=0x1234;
//    undefined: be=01, data=0x0034, iocs16_oe=0.

Source files
------------

// File: rtl/isa_io_pkg.sv
// Shared types and constants for the ISA I/O target.
// ISA_IOCS16_EN selects the 16-bit responder; undefined builds an 8-bit target.
package isa_io_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned BE_W   = 2;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DRIVE,
        WR_PUSH,
        WR_STALL,
        DONE
    } state_t;

    typedef struct packed {
        logic [REG_W-1:0]  addr;
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be;
    } wr_entry_t;

    localparam logic [DATA_W-1:0] RD_TIMEOUT_DATA = 16'hFFFF;

`ifdef ISA_IOCS16_EN
    localparam logic [DATA_W-1:0] DATA_MASK = 16'hFFFF;
    localparam logic              BE_HI_EN  = 1'b1;
`else
    localparam logic [DATA_W-1:0] DATA_MASK = 16'h00FF;
    localparam logic              BE_HI_EN  = 1'b0;
`endif

    // Low byte is always enabled; the high byte only on a 16-bit responder with SBHE# low.
    function automatic logic [BE_W-1:0] byte_enables(input logic sbhe_n);
        return {BE_HI_EN & ~sbhe_n, 1'b1};
    endfunction

endpackage

// File: rtl/isa_io_wr_fifo.sv
// Synchronous write FIFO of wr_entry_t; wrap-bit pointers give full/empty.
module isa_io_wr_fifo
    import isa_io_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  wr_entry_t push_entry,
    input  logic      pop,
    output wr_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wr_entry_t     mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push in the cycle it is popped.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_entry;
    end

endmodule

// File: rtl/isa_io_target.sv
// ISA I/O-cycle target: synchronises strobes, decodes a 16-register window and bridges to fabric.
// ISA_IOCS16_EN defined builds a 16-bit responder driving IOCS16#.
module isa_io_target
    import isa_io_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'h0220,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned WAIT_MAX    = 64,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       isa_sa,
    input  logic              isa_aen,
    input  logic              isa_ior_n,
    input  logic              isa_iow_n,
    input  logic              isa_sbhe_n,
    input  logic [DATA_W-1:0] isa_data_in,
    output logic [DATA_W-1:0] isa_data_out,
    output logic              isa_data_oe,
    output logic              isa_iochrdy_oe,
    output logic              isa_iocs16_oe,
    output logic              rd_req,
    output logic [REG_W-1:0]  rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_valid,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [REG_W-1:0]  wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [BE_W-1:0]   wr_be,
    output logic              timeout
);

    localparam int unsigned WCW = $clog2(WAIT_MAX + 1);

    logic [SYNC_STAGES-1:0] ior_sync;
    logic [SYNC_STAGES-1:0] iow_sync;
    logic [SYNC_STAGES-1:0] aen_sync;
    logic                   ior_s;
    logic                   iow_s;
    logic                   aen_s;
    logic                   ior_s_d;
    logic                   iow_s_d;
    logic                   ior_fall;
    logic                   iow_fall;
    logic                   hit_c;

    state_t                 state;
    logic [WCW-1:0]         wait_cnt;
    logic                   wait_expire;
    logic [REG_W-1:0]       sa_q;
    logic                   sbhe_q;

    wr_entry_t              push_entry;
    wr_entry_t              head;
    logic                   push_c;
    logic                   pop_c;
    logic                   fifo_full;
    logic                   fifo_empty;

    // Strobe/AEN synchronisers; idle strobes high and DMA asserted so reset raises no edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ior_sync <= '1;
            iow_sync <= '1;
            aen_sync <= '1;
            ior_s_d  <= 1'b1;
            iow_s_d  <= 1'b1;
        end else begin
            ior_sync <= {ior_sync[SYNC_STAGES-2:0], isa_ior_n};
            iow_sync <= {iow_sync[SYNC_STAGES-2:0], isa_iow_n};
            aen_sync <= {aen_sync[SYNC_STAGES-2:0], isa_aen};
            ior_s_d  <= ior_s;
            iow_s_d  <= iow_s;
        end
    end

    assign ior_s       = ior_sync[SYNC_STAGES-1];
    assign iow_s       = iow_sync[SYNC_STAGES-1];
    assign aen_s       = aen_sync[SYNC_STAGES-1];
    assign ior_fall    = ior_s_d & ~ior_s;
    assign iow_fall    = iow_s_d & ~iow_s;
    assign hit_c       = !aen_s && (isa_sa[15:4] == BASE_ADDR[15:4]);
    assign wait_expire = (wait_cnt == WCW'(WAIT_MAX - 1));

`ifdef ISA_IOCS16_EN
    assign isa_iocs16_oe = hit_c & ~reset;
`else
    assign isa_iocs16_oe = 1'b0;
`endif

    // Write data is taken on the push edge, at least two cycles after the strobe edge.
    assign push_c     = (state == WR_PUSH) && (wait_cnt != '0);
    assign pop_c      = !fifo_empty && wr_ready;
    assign push_entry = '{addr: sa_q, data: isa_data_in & DATA_MASK, be: byte_enables(sbhe_q)};

    // Cycle FSM with registered bus and fabric outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            sa_q           <= '0;
            sbhe_q         <= 1'b1;
            rd_req         <= 1'b0;
            rd_addr        <= '0;
            isa_data_out   <= '0;
            isa_data_oe    <= 1'b0;
            isa_iochrdy_oe <= 1'b0;
            timeout        <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (state != IDLE && wait_cnt != WCW'(WAIT_MAX)) wait_cnt <= wait_cnt + WCW'(1);

            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (ior_fall && hit_c) begin
                        rd_req         <= 1'b1;
                        rd_addr        <= isa_sa[3:0];
                        isa_iochrdy_oe <= 1'b1;
                        state          <= RD_WAIT;
                    end else if (iow_fall && ior_s && hit_c) begin
                        sa_q   <= isa_sa[3:0];
                        sbhe_q <= isa_sbhe_n;
                        if (fifo_full) begin
                            isa_iochrdy_oe <= 1'b1;
                            state          <= WR_STALL;
                        end else begin
                            state <= WR_PUSH;
                        end
                    end
                end
                RD_WAIT: begin
                    if (rd_valid) begin
                        isa_data_out   <= rd_data & DATA_MASK;
                        rd_req         <= 1'b0;
                        isa_iochrdy_oe <= 1'b0;
                        isa_data_oe    <= 1'b1;
                        state          <= RD_DRIVE;
                    end else if (wait_expire) begin
                        isa_data_out   <= RD_TIMEOUT_DATA & DATA_MASK;
                        rd_req         <= 1'b0;
                        isa_iochrdy_oe <= 1'b0;
                        isa_data_oe    <= 1'b1;
                        timeout        <= 1'b1;
                        state          <= RD_DRIVE;
                    end
                end
                RD_DRIVE: begin
                    if (ior_s) begin
                        isa_data_oe <= 1'b0;
                        state       <= DONE;
                    end
                end
                WR_STALL: begin
                    if (!fifo_full || pop_c) begin
                        state <= WR_PUSH;
                    end else if (wait_expire) begin
                        isa_iochrdy_oe <= 1'b0;
                        timeout        <= 1'b1;
                        state          <= DONE;
                    end
                end
                WR_PUSH: begin
                    if (push_c) begin
                        isa_iochrdy_oe <= 1'b0;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    if (ior_s && iow_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    isa_io_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push_c),
        .push_entry (push_entry),
        .pop        (pop_c),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign wr_valid = ~fifo_empty;
    assign wr_addr  = head.addr;
    assign wr_data  = head.data;
    assign wr_be    = head.be;

endmodule

// File: tb/tb_isa_io_target.sv
// Directed bench for isa_io_target: reads, misses, write FIFO, timeouts, reset, bus width.
module tb_isa_io_target;

    localparam int unsigned WAIT_MAX = 64;
`ifdef ISA_IOCS16_EN
    localparam logic [15:0] DMASK    = 16'hFFFF;
    localparam logic [1:0]  BE_HI    = 2'b11;
    localparam logic        CS16_EXP = 1'b1;
`else
    localparam logic [15:0] DMASK    = 16'h00FF;
    localparam logic [1:0]  BE_HI    = 2'b01;
    localparam logic        CS16_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] isa_sa;
    logic        isa_aen;
    logic        isa_ior_n;
    logic        isa_iow_n;
    logic        isa_sbhe_n;
    logic [15:0] isa_data_in;
    logic [15:0] isa_data_out;
    logic        isa_data_oe;
    logic        isa_iochrdy_oe;
    logic        isa_iocs16_oe;
    logic        rd_req;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    isa_io_target dut (
        .clk            (clk),
        .reset          (reset),
        .isa_sa         (isa_sa),
        .isa_aen        (isa_aen),
        .isa_ior_n      (isa_ior_n),
        .isa_iow_n      (isa_iow_n),
        .isa_sbhe_n     (isa_sbhe_n),
        .isa_data_in    (isa_data_in),
        .isa_data_out   (isa_data_out),
        .isa_data_oe    (isa_data_oe),
        .isa_iochrdy_oe (isa_iochrdy_oe),
        .isa_iocs16_oe  (isa_iocs16_oe),
        .rd_req         (rd_req),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_be          (wr_be),
        .timeout        (timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait up to budget cycles for a DUT output: 0 iochrdy_oe, 1 rd_req, 2 timeout.
    task automatic await(input int sel, input int budget, output bit ok, output int cycles);
        ok = 1'b0;
        cycles = 0;
        for (int c = 0; c < budget; c++) begin
            tick();
            cycles++;
            if ((sel == 0 && isa_iochrdy_oe) || (sel == 1 && rd_req) || (sel == 2 && timeout)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic isa_write(input logic [15:0] a, input logic [15:0] d, input logic sbhe_n);
        isa_sa      = a;
        isa_data_in = d;
        isa_sbhe_n  = sbhe_n;
        isa_iow_n   = 1'b0;
        repeat (8) tick();
        isa_iow_n   = 1'b1;
        repeat (5) tick();
    endtask

    task automatic miss_probe(input string tag);
        bit bad;
        bad = 1'b0;
        isa_ior_n = 1'b0;
        repeat (10) begin
            tick();
            bad |= rd_req | isa_data_oe | isa_iochrdy_oe;
        end
        isa_ior_n = 1'b1;
        repeat (4) tick();
        check(tag, 32'(bad), 32'd0);
    endtask

    // Pops everything with wr_ready high; returns count and the last address seen.
    task automatic drain(output int popped, output logic [3:0] last_addr);
        popped = 0;
        last_addr = '0;
        wr_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (wr_valid) begin
                last_addr = wr_addr;
                popped++;
            end
            tick();
        end
        wr_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        int          n;
        int          popped;
        logic [3:0]  last_a;
        logic [15:0] exp_data [9];

        reset = 1'b1; isa_sa = '0; isa_aen = 1'b0; isa_ior_n = 1'b1; isa_iow_n = 1'b1;
        isa_sbhe_n = 1'b1; isa_data_in = '0; rd_data = '0; rd_valid = 1'b0; wr_ready = 1'b0;
        repeat (3) tick();

        check("rst_data_oe", 32'(isa_data_oe), 32'd0);
        check("rst_iochrdy", 32'(isa_iochrdy_oe), 32'd0);
        check("rst_iocs16", 32'(isa_iocs16_oe), 32'd0);
        check("rst_rd_req", 32'(rd_req), 32'd0);
        check("rst_wr_valid", 32'(wr_valid), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_data_out", 32'(isa_data_out), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        reset = 1'b0;
        repeat (3) tick();

        // Read hit with rd_valid five cycles after the request
        isa_sa = 16'h022A;
        isa_ior_n = 1'b0;
        await(0, 8, ok, n);
        check("rd_iochrdy", 32'(ok), 32'd1);
        check("rd_req", 32'(rd_req), 32'd1);
        check("rd_addr", 32'(rd_addr), 32'hA);
        check("rd_oe_wait", 32'(isa_data_oe), 32'd0);
        repeat (5) tick();
        rd_data = 16'hBEEF; rd_valid = 1'b1;
        tick();
        rd_valid = 1'b0; rd_data = '0;
        check("rd_oe", 32'(isa_data_oe), 32'd1);
        check("rd_data", 32'(isa_data_out), 32'(16'hBEEF & DMASK));
        check("rd_rdy_rel", 32'(isa_iochrdy_oe), 32'd0);
        check("rd_req_rel", 32'(rd_req), 32'd0);
        repeat (4) tick();
        check("rd_oe_hold", 32'(isa_data_oe), 32'd1);
        isa_ior_n = 1'b1;
        repeat (5) tick();
        check("rd_oe_off", 32'(isa_data_oe), 32'd0);

        // Address miss and DMA cycle
        isa_sa = 16'h0330;
        tick();
        check("miss_iocs16", 32'(isa_iocs16_oe), 32'd0);
        miss_probe("miss_addr");
        isa_aen = 1'b1; isa_sa = 16'h0224;
        repeat (4) tick();
        miss_probe("miss_dma");
        isa_aen = 1'b0;
        repeat (4) tick();

        // Write burst fills the FIFO; ninth write stalls until a slot frees
        for (int i = 0; i < 8; i++) begin
            exp_data[i] = 16'(16'h1111 * (i + 1));
            isa_write(16'h0220 + 16'(i), exp_data[i], 1'b1);
        end
        exp_data[8] = 16'h5A5A;
        check("wb_valid", 32'(wr_valid), 32'd1);
        isa_sa = 16'h0228; isa_data_in = 16'h5A5A; isa_sbhe_n = 1'b1; isa_iow_n = 1'b0;
        await(0, 8, ok, n);
        check("wb_stall", 32'(ok), 32'd1);
        repeat (3) tick();
        check("wb_stall_hold", 32'(isa_iochrdy_oe), 32'd1);
        wr_ready = 1'b1;
        popped = 0;
        for (int c = 0; c < 30; c++) begin
            if (wr_valid) begin
                if (popped < 9)
                    check("wb_entry", 32'({wr_addr, wr_data, wr_be}),
                          32'({4'(popped), exp_data[popped] & DMASK, 2'b01}));
                else
                    check("wb_extra", 32'd1, 32'd0);
                popped++;
            end
            tick();
        end
        wr_ready = 1'b0;
        check("wb_count", 32'(popped), 32'd9);
        check("wb_rdy_rel", 32'(isa_iochrdy_oe), 32'd0);
        isa_iow_n = 1'b1;
        repeat (5) tick();

        // Read timeout: rd_valid withheld
        isa_sa = 16'h0225;
        isa_ior_n = 1'b0;
        await(0, 8, ok, n);
        check("rto_start", 32'(ok), 32'd1);
        await(2, WAIT_MAX + 8, ok, n);
        check("rto_pulse", 32'(ok), 32'd1);
        check("rto_cycles", 32'(n), 32'(WAIT_MAX));
        check("rto_data", 32'(isa_data_out), 32'(16'hFFFF & DMASK));
        check("rto_oe", 32'(isa_data_oe), 32'd1);
        check("rto_rdy", 32'(isa_iochrdy_oe), 32'd0);
        check("rto_req", 32'(rd_req), 32'd0);
        rd_data = 16'h1111; rd_valid = 1'b1;
        tick();
        rd_valid = 1'b0;
        check("rto_one_shot", 32'(timeout), 32'd0);
        tick();
        check("rto_late_valid", 32'(isa_data_out), 32'(16'hFFFF & DMASK));
        isa_ior_n = 1'b1;
        repeat (5) tick();

        // Write timeout on a full FIFO drops the entry
        for (int i = 0; i < 8; i++) isa_write(16'h0220 + 16'(i), 16'h2000 + 16'(i), 1'b1);
        isa_sa = 16'h022F; isa_data_in = 16'hDEAD; isa_iow_n = 1'b0;
        await(0, 8, ok, n);
        check("wto_stall", 32'(ok), 32'd1);
        await(2, WAIT_MAX + 8, ok, n);
        check("wto_pulse", 32'(ok), 32'd1);
        check("wto_rdy", 32'(isa_iochrdy_oe), 32'd0);
        isa_iow_n = 1'b1;
        repeat (5) tick();
        drain(popped, last_a);
        check("wto_count", 32'(popped), 32'd8);
        check("wto_last", 32'(last_a), 32'd7);

        // Reset in RD_WAIT releases the bus immediately
        isa_sa = 16'h0223;
        isa_ior_n = 1'b0;
        await(1, 8, ok, n);
        check("rst_mid_start", 32'(ok), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_req", 32'(rd_req), 32'd0);
        check("rst_mid_rdy", 32'(isa_iochrdy_oe), 32'd0);
        check("rst_mid_oe", 32'(isa_data_oe), 32'd0);
        isa_ior_n = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (3) tick();
        isa_sa = 16'h0229;
        isa_ior_n = 1'b0;
        await(1, 8, ok, n);
        check("post_rst_req", 32'(ok), 32'd1);
        check("post_rst_addr", 32'(rd_addr), 32'd9);
        rd_data = 16'h4321; rd_valid = 1'b1;
        tick();
        rd_valid = 1'b0;
        check("post_rst_data", 32'(isa_data_out), 32'(16'h4321 & DMASK));
        check("post_rst_oe", 32'(isa_data_oe), 32'd1);
        isa_ior_n = 1'b1;
        repeat (5) tick();

        // Simultaneous strobes: read wins, write is not queued
        isa_sa = 16'h0226;
        isa_ior_n = 1'b0; isa_iow_n = 1'b0;
        await(1, 8, ok, n);
        check("both_rd", 32'(ok), 32'd1);
        rd_data = 16'h0042; rd_valid = 1'b1;
        tick();
        rd_valid = 1'b0;
        isa_ior_n = 1'b1; isa_iow_n = 1'b1;
        repeat (5) tick();
        check("both_no_wr", 32'(wr_valid), 32'd0);

        // Bus width: SBHE# low with 0x1234
        isa_sa = 16'h0221; isa_data_in = 16'h1234; isa_sbhe_n = 1'b0; isa_iow_n = 1'b0;
        repeat (8) tick();
        check("bw_iocs16", 32'(isa_iocs16_oe), 32'(CS16_EXP));
        isa_iow_n = 1'b1; isa_sbhe_n = 1'b1;
        repeat (5) tick();
        check("bw_valid", 32'(wr_valid), 32'd1);
        check("bw_addr", 32'(wr_addr), 32'd1);
        check("bw_data", 32'(wr_data), 32'(16'h1234 & DMASK));
        check("bw_be", 32'(wr_be), 32'(BE_HI));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
